hazard_control_unit: RTL and testbench
======================================

# hazard_control_unit

Pipeline hazard controller for the five-stage RISC-V core: decides, every cycle, the stall and clear controls for the program counter and the fetch, decoding, execution and memory stage output registers. It covers load-use hazards, taken-branch flushes, and instruction/data cache misses. It also keeps a registered hazard state, saturating performance counters and a sticky data-cache-miss timeout flag. It sits beside the pipeline and drives STALL_DECODING_STAGE / CLEAR_DECODING_STAGE and their siblings.

## Interface
- DMISS_TIMEOUT, 1024, consecutive data-miss cycles after which MISS_TIMEOUT sets (1..65535)
- CLK  input  1  clock, all state updates on rising edge
- RST  input  1  reset, asynchronous, active-high
- RS1_ADDRESS  input  5  rs1 of instruction in decode
- RS2_ADDRESS  input  5  rs2 of instruction in decode
- RS1_READ  input  1  decode instruction reads rs1
- RS2_READ  input  1  decode instruction reads rs2
- RD_ADDRESS_EXECUTION  input  5  rd of instruction in execution
- RD_WRITE_ENABLE_EXECUTION  input  1  execution instruction writes rd
- DATA_CACHE_LOAD_EXECUTION  input  3  load type in execution; nonzero = load
- BRANCH_TAKEN  input  1  execution resolved a taken branch/jump
- INSTRUCTION_CACHE_READY  input  1  fetch data valid this cycle
- MEMORY_ACCESS_VALID  input  1  memory stage holds a load/store
- DATA_CACHE_READY  input  1  data cache completes access this cycle
- COUNTERS_CLEAR  input  1  synchronous clear of counters and MISS_TIMEOUT
- STALL_PROGRAM_COUNTER  output  1  hold PC
- STALL_FETCHING_STAGE, STALL_DECODING_STAGE, STALL_EXECUTION_STAGE, STALL_MEMORY_STAGE  output  1 each  hold stage register
- CLEAR_FETCHING_STAGE, CLEAR_DECODING_STAGE, CLEAR_EXECUTION_STAGE, CLEAR_MEMORY_STAGE  output  1 each  load bubble into stage register
- HAZARD_STATE  output  3  registered condition of previous cycle
- STALL_CYCLES  output  32  saturating count of non-RUN cycles
- FLUSH_COUNT  output  32  saturating count of branch flushes
- MISS_TIMEOUT  output  1  sticky data-miss timeout

## Operation
- Condition evaluated combinationally each cycle, strict priority:
  - DMISS (4): MEMORY_ACCESS_VALID & !DATA_CACHE_READY → all five STALL_* = 1, all CLEAR_* = 0.
  - FLUSH (3): BRANCH_TAKEN → CLEAR_FETCHING_STAGE = CLEAR_DECODING_STAGE = 1, no stalls.
  - LOAD_USE (2): DATA_CACHE_LOAD_EXECUTION != 0 & RD_WRITE_ENABLE_EXECUTION & RD_ADDRESS_EXECUTION != 0 & ((RS1_READ & RS1_ADDRESS == rd) | (RS2_READ & RS2_ADDRESS == rd)) → STALL_PROGRAM_COUNTER = STALL_FETCHING_STAGE = 1, CLEAR_DECODING_STAGE = 1.
  - IMISS (1): !INSTRUCTION_CACHE_READY → STALL_PROGRAM_COUNTER = 1, CLEAR_FETCHING_STAGE = 1.
  - RUN (0): all controls 0.
- Exactly one condition is active per cycle. Stall and clear are never both 1 for the same register.
- Only the listed outputs are 1; all others are 0.
- HAZARD_STATE <= active condition code at each edge.
- STALL_CYCLES: +1 at each edge where the condition != RUN; saturates at 0xFFFFFFFF.
- FLUSH_COUNT: +1 at each edge where the condition == FLUSH; saturates. A branch masked by DMISS is not counted; it is counted once the freeze lifts, since execution is held.
- Miss timer, 16-bit:
  - +1 per DMISS cycle; cleared on any non-DMISS cycle.
  - When it reaches DMISS_TIMEOUT, MISS_TIMEOUT <= 1.
  - MISS_TIMEOUT stays 1 until RST or COUNTERS_CLEAR; the timer holds at the limit.
- COUNTERS_CLEAR zeroes STALL_CYCLES, FLUSH_COUNT, the miss timer and MISS_TIMEOUT, overriding increments that edge. It does not affect HAZARD_STATE or the controls.

## Timing
- Controls are combinational from inputs: zero latency, same-cycle effect at the next edge.
- HAZARD_STATE, counters and MISS_TIMEOUT are registered: one edge of latency.
- While RST = 1:
  - all four CLEAR_* = 1, all STALL_* = 0, so the pipeline fills with bubbles.
  - HAZARD_STATE = 0, counters = 0, MISS_TIMEOUT = 0.
- Reset asserted mid-DMISS or mid-flush aborts immediately and asynchronously. After release, evaluation restarts from RUN.
- Load-use lasts exactly one cycle in normal flow: the bubble moves the load to memory next cycle.
- Load-use that coincides with DMISS is stalled and resolved after the miss.
- rd = x0 never creates a load-use hazard.

## Test plan
- Reset: RST = 1 mid-DMISS with STALL_CYCLES = 5 → CLEAR_* = 1, STALL_* = 0, HAZARD_STATE = 0, STALL_CYCLES = 0 immediately; after release with RUN inputs, all controls are 0.
- Load-use: DATA_CACHE_LOAD_EXECUTION = 3'b011, rd = 8, RS1_ADDRESS = 8, RS1_READ = 1 for one cycle → STALL_PROGRAM_COUNTER = STALL_FETCHING_STAGE = CLEAR_DECODING_STAGE = 1, then HAZARD_STATE = 2, STALL_CYCLES = 1. Repeat with rd = 0 → no stall. Repeat with RS2 matching but RS2_READ = 0 → no stall.
- Priority: BRANCH_TAKEN = 1 together with a load-use match and INSTRUCTION_CACHE_READY = 0 → only CLEAR_FETCHING_STAGE and CLEAR_DECODING_STAGE, HAZARD_STATE = 3, FLUSH_COUNT = 1.
- Data miss: MEMORY_ACCESS_VALID = 1, DATA_CACHE_READY = 0 for 3 cycles with BRANCH_TAKEN = 1 → all STALL_* = 1 for 3 cycles, FLUSH_COUNT = 0. Ready on cycle 4 → flush that cycle, FLUSH_COUNT = 1, STALL_CYCLES = 4.
- Timeout: DMISS_TIMEOUT = 4, 4 consecutive DMISS cycles → MISS_TIMEOUT = 1 after the 4th edge and remains 1 after ready. COUNTERS_CLEAR → 0. 3-cycle miss, 1 ready cycle, 3-cycle miss → MISS_TIMEOUT stays 0.
- Saturation: STALL_CYCLES preloaded to 0xFFFFFFFE by 0xFFFFFFFE stall cycles (or force) then 3 IMISS cycles → holds 0xFFFFFFFF.

Source files
------------

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: pipeline stall/clear control with hazard state, perf counters and data-miss timeout
// Inputs: decode rs1/rs2 usage, execution rd/load info, BRANCH_TAKEN, cache ready/valid, COUNTERS_CLEAR
// Outputs: STALL_*/CLEAR_* per stage (combinational), HAZARD_STATE, STALL_CYCLES, FLUSH_COUNT, MISS_TIMEOUT (registered)
module hazard_control_unit #(
  parameter int DMISS_TIMEOUT = 1024
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [4:0]  RS1_ADDRESS,
  input  logic [4:0]  RS2_ADDRESS,
  input  logic        RS1_READ,
  input  logic        RS2_READ,
  input  logic [4:0]  RD_ADDRESS_EXECUTION,
  input  logic        RD_WRITE_ENABLE_EXECUTION,
  input  logic [2:0]  DATA_CACHE_LOAD_EXECUTION,
  input  logic        BRANCH_TAKEN,
  input  logic        INSTRUCTION_CACHE_READY,
  input  logic        MEMORY_ACCESS_VALID,
  input  logic        DATA_CACHE_READY,
  input  logic        COUNTERS_CLEAR,
  output logic        STALL_PROGRAM_COUNTER,
  output logic        STALL_FETCHING_STAGE,
  output logic        STALL_DECODING_STAGE,
  output logic        STALL_EXECUTION_STAGE,
  output logic        STALL_MEMORY_STAGE,
  output logic        CLEAR_FETCHING_STAGE,
  output logic        CLEAR_DECODING_STAGE,
  output logic        CLEAR_EXECUTION_STAGE,
  output logic        CLEAR_MEMORY_STAGE,
  output logic [2:0]  HAZARD_STATE,
  output logic [31:0] STALL_CYCLES,
  output logic [31:0] FLUSH_COUNT,
  output logic        MISS_TIMEOUT
);
  typedef enum logic [2:0] {RUN, IMISS, LOAD_USE, FLUSH, DMISS} cond_t;
  localparam logic [15:0] LIMIT = 16'(DMISS_TIMEOUT);
  cond_t cond;
  logic load_use;
  logic [15:0] timer, timer_inc;
  always_comb begin
    load_use = DATA_CACHE_LOAD_EXECUTION != 3'd0 && RD_WRITE_ENABLE_EXECUTION && RD_ADDRESS_EXECUTION != 5'd0 &&
               ((RS1_READ && RS1_ADDRESS == RD_ADDRESS_EXECUTION) || (RS2_READ && RS2_ADDRESS == RD_ADDRESS_EXECUTION));
    cond = (MEMORY_ACCESS_VALID && !DATA_CACHE_READY) ? DMISS :
           BRANCH_TAKEN ? FLUSH :
           load_use ? LOAD_USE :
           !INSTRUCTION_CACHE_READY ? IMISS : RUN;
    timer_inc = timer == LIMIT ? timer : timer + 16'd1;
  end
  // Reset forces bubbles into every stage register and suppresses all stalls.
  assign STALL_PROGRAM_COUNTER = !RST && (cond == DMISS || cond == LOAD_USE || cond == IMISS);
  assign STALL_FETCHING_STAGE  = !RST && (cond == DMISS || cond == LOAD_USE);
  assign STALL_DECODING_STAGE  = !RST && cond == DMISS;
  assign STALL_EXECUTION_STAGE = !RST && cond == DMISS;
  assign STALL_MEMORY_STAGE    = !RST && cond == DMISS;
  assign CLEAR_FETCHING_STAGE  = RST || cond == FLUSH || cond == IMISS;
  assign CLEAR_DECODING_STAGE  = RST || cond == FLUSH || cond == LOAD_USE;
  assign CLEAR_EXECUTION_STAGE = RST;
  assign CLEAR_MEMORY_STAGE    = RST;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      HAZARD_STATE <= 3'd0;
      STALL_CYCLES <= '0;
      FLUSH_COUNT  <= '0;
      timer        <= '0;
      MISS_TIMEOUT <= 1'b0;
    end else begin
      HAZARD_STATE <= cond;
      if (COUNTERS_CLEAR) begin
        STALL_CYCLES <= '0;
        FLUSH_COUNT  <= '0;
        timer        <= '0;
        MISS_TIMEOUT <= 1'b0;
      end else begin
        if (cond != RUN && STALL_CYCLES != '1) STALL_CYCLES <= STALL_CYCLES + 32'd1;
        if (cond == FLUSH && FLUSH_COUNT != '1) FLUSH_COUNT <= FLUSH_COUNT + 32'd1;
        timer <= cond == DMISS ? timer_inc : '0;
        if (cond == DMISS && timer_inc == LIMIT) MISS_TIMEOUT <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: directed bench with a behavioural model and per-cycle comparison
module tb_hazard_control_unit;
  localparam int LIM = 4;
  logic CLK, RST;
  logic [4:0] RS1_ADDRESS, RS2_ADDRESS, RD_ADDRESS_EXECUTION;
  logic RS1_READ, RS2_READ, RD_WRITE_ENABLE_EXECUTION, BRANCH_TAKEN;
  logic [2:0] DATA_CACHE_LOAD_EXECUTION;
  logic INSTRUCTION_CACHE_READY, MEMORY_ACCESS_VALID, DATA_CACHE_READY, COUNTERS_CLEAR;
  logic spc, sf, sd, se, sm, cf, cd, ce, cm, to;
  logic [2:0] hs;
  logic [31:0] sc, fc;
  int checks = 0, failures = 0;
  bit skip_sc = 0;
  logic [2:0] m_state;
  logic [31:0] m_sc, m_fc;
  int m_timer;
  logic m_to;
  // Control vector order: {pc, f, d, e, m stalls, f, d, e, m clears}, indexed by condition code.
  localparam logic [8:0] CTRL_TAB [5] = '{9'b00000_0000, 9'b10000_1000, 9'b11000_0100, 9'b00000_1100, 9'b11111_0000};

  hazard_control_unit #(.DMISS_TIMEOUT(LIM)) dut (
    .CLK(CLK), .RST(RST),
    .RS1_ADDRESS(RS1_ADDRESS), .RS2_ADDRESS(RS2_ADDRESS), .RS1_READ(RS1_READ), .RS2_READ(RS2_READ),
    .RD_ADDRESS_EXECUTION(RD_ADDRESS_EXECUTION), .RD_WRITE_ENABLE_EXECUTION(RD_WRITE_ENABLE_EXECUTION),
    .DATA_CACHE_LOAD_EXECUTION(DATA_CACHE_LOAD_EXECUTION), .BRANCH_TAKEN(BRANCH_TAKEN),
    .INSTRUCTION_CACHE_READY(INSTRUCTION_CACHE_READY), .MEMORY_ACCESS_VALID(MEMORY_ACCESS_VALID),
    .DATA_CACHE_READY(DATA_CACHE_READY), .COUNTERS_CLEAR(COUNTERS_CLEAR),
    .STALL_PROGRAM_COUNTER(spc), .STALL_FETCHING_STAGE(sf), .STALL_DECODING_STAGE(sd),
    .STALL_EXECUTION_STAGE(se), .STALL_MEMORY_STAGE(sm),
    .CLEAR_FETCHING_STAGE(cf), .CLEAR_DECODING_STAGE(cd), .CLEAR_EXECUTION_STAGE(ce), .CLEAR_MEMORY_STAGE(cm),
    .HAZARD_STATE(hs), .STALL_CYCLES(sc), .FLUSH_COUNT(fc), .MISS_TIMEOUT(to)
  );

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  function automatic int model_cond();
    if (MEMORY_ACCESS_VALID && !DATA_CACHE_READY) return 4;
    if (BRANCH_TAKEN) return 3;
    if (DATA_CACHE_LOAD_EXECUTION != 0 && RD_WRITE_ENABLE_EXECUTION && RD_ADDRESS_EXECUTION != 0 &&
        ((RS1_READ && RS1_ADDRESS == RD_ADDRESS_EXECUTION) || (RS2_READ && RS2_ADDRESS == RD_ADDRESS_EXECUTION)))
      return 2;
    if (!INSTRUCTION_CACHE_READY) return 1;
    return 0;
  endfunction

  always @(posedge CLK or posedge RST) begin
    int c, nt;
    if (RST) begin
      m_state <= 0; m_sc <= 0; m_fc <= 0; m_timer <= 0; m_to <= 0;
    end else begin
      c = model_cond();
      m_state <= 3'(c);
      if (COUNTERS_CLEAR) begin
        m_sc <= 0; m_fc <= 0; m_timer <= 0; m_to <= 0;
      end else begin
        if (c != 0) m_sc <= (m_sc == 32'hFFFF_FFFF) ? m_sc : m_sc + 1;
        if (c == 3) m_fc <= (m_fc == 32'hFFFF_FFFF) ? m_fc : m_fc + 1;
        if (c == 4) begin
          nt = (m_timer + 1 > LIM) ? LIM : m_timer + 1;
          m_timer <= nt;
          if (nt == LIM) m_to <= 1;
        end else m_timer <= 0;
      end
    end
  end

  function automatic logic [8:0] ctrl();
    return {spc, sf, sd, se, sm, cf, cd, ce, cm};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("ctrl", 32'(ctrl()), 32'(RST ? 9'b00000_1111 : CTRL_TAB[model_cond()]));
    chk("hazard_state", 32'(hs), 32'(m_state));
    if (!skip_sc) chk("stall_cycles", sc, m_sc);
    chk("flush_count", fc, m_fc);
    chk("miss_timeout", 32'(to), 32'(m_to));
  endtask

  task automatic cyc();
    @(negedge CLK);
    check_all();
    @(posedge CLK);
    #2;
  endtask

  task automatic set_run();
    RS1_ADDRESS = 0; RS2_ADDRESS = 0; RS1_READ = 0; RS2_READ = 0;
    RD_ADDRESS_EXECUTION = 0; RD_WRITE_ENABLE_EXECUTION = 0; DATA_CACHE_LOAD_EXECUTION = 0;
    BRANCH_TAKEN = 0; INSTRUCTION_CACHE_READY = 1; MEMORY_ACCESS_VALID = 0; DATA_CACHE_READY = 1;
    COUNTERS_CLEAR = 0;
  endtask

  task automatic set_lu();
    DATA_CACHE_LOAD_EXECUTION = 3'b011; RD_WRITE_ENABLE_EXECUTION = 1; RD_ADDRESS_EXECUTION = 8;
    RS1_ADDRESS = 8; RS1_READ = 1;
  endtask

  task automatic set_dmiss();
    MEMORY_ACCESS_VALID = 1; DATA_CACHE_READY = 0;
  endtask

  task automatic clear_counters();
    COUNTERS_CLEAR = 1;
    cyc();
    COUNTERS_CLEAR = 0;
  endtask

  initial begin
    RST = 1;
    set_run();
    @(posedge CLK);
    #2;
    chk("rst_ctrl", 32'(ctrl()), 32'h00F);
    chk("rst_state", 32'(hs), 0);
    cyc();
    RST = 0;
    cyc();
    // load-use on rs1
    set_lu();
    #1 chk("lu_ctrl", 32'(ctrl()), 32'b11000_0100);
    cyc();
    chk("lu_state", 32'(hs), 2);
    chk("lu_sc", sc, 1);
    // rd = x0
    RD_ADDRESS_EXECUTION = 0; RS1_ADDRESS = 0;
    #1 chk("x0_ctrl", 32'(ctrl()), 0);
    cyc();
    chk("x0_state", 32'(hs), 0);
    // rs2 matches but is not read, then read
    RD_ADDRESS_EXECUTION = 8; RS1_ADDRESS = 1; RS2_ADDRESS = 8; RS2_READ = 0;
    #1 chk("rs2_noread_ctrl", 32'(ctrl()), 0);
    cyc();
    RS2_READ = 1;
    cyc();
    // branch outranks load-use and imiss
    set_run(); set_lu(); BRANCH_TAKEN = 1; INSTRUCTION_CACHE_READY = 0;
    #1 chk("prio_ctrl", 32'(ctrl()), 32'b00000_1100);
    cyc();
    chk("prio_state", 32'(hs), 3);
    chk("prio_fc", fc, 1);
    set_run();
    clear_counters();
    chk("clr_sc", sc, 0);
    chk("clr_fc", fc, 0);
    // data miss masks a branch, branch counted after ready
    set_dmiss(); BRANCH_TAKEN = 1;
    repeat (3) begin
      #1 chk("dmiss_ctrl", 32'(ctrl()), 32'b11111_0000);
      cyc();
    end
    chk("dmiss_fc", fc, 0);
    DATA_CACHE_READY = 1;
    #1 chk("dready_ctrl", 32'(ctrl()), 32'b00000_1100);
    cyc();
    chk("dready_fc", fc, 1);
    chk("dready_sc", sc, 4);
    chk("dready_to", 32'(to), 0);
    set_run();
    cyc();
    // timeout
    set_dmiss();
    repeat (4) cyc();
    chk("to_set", 32'(to), 1);
    DATA_CACHE_READY = 1;
    repeat (2) cyc();
    chk("to_sticky", 32'(to), 1);
    clear_counters();
    chk("to_cleared", 32'(to), 0);
    DATA_CACHE_READY = 0;
    repeat (3) cyc();
    DATA_CACHE_READY = 1;
    cyc();
    DATA_CACHE_READY = 0;
    repeat (3) cyc();
    chk("to_split", 32'(to), 0);
    set_run();
    clear_counters();
    // reset mid-miss
    set_dmiss();
    repeat (5) cyc();
    chk("pre_rst_sc", sc, 5);
    #1 RST = 1;
    #1;
    chk("arst_ctrl", 32'(ctrl()), 32'h00F);
    chk("arst_state", 32'(hs), 0);
    chk("arst_sc", sc, 0);
    chk("arst_to", 32'(to), 0);
    cyc();
    RST = 0;
    set_run();
    #1 chk("post_rst_ctrl", 32'(ctrl()), 0);
    repeat (2) cyc();
    // saturation
    clear_counters();
    INSTRUCTION_CACHE_READY = 0;
    skip_sc = 1;
    force dut.STALL_CYCLES = 32'hFFFF_FFFE;
    cyc();
    release dut.STALL_CYCLES;
    cyc();
    chk("sat_sc2", sc, 32'hFFFF_FFFF);
    cyc();
    chk("sat_sc3", sc, 32'hFFFF_FFFF);
    set_run();
    clear_counters();
    skip_sc = 0;
    repeat (2) cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
